// File: rtl/turn_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : turn_sequencer_if                                      |
// | Description : Requester/board bus bundle for turn_sequencer. The     |
// |               master side is the environment, which drives the       |
// |               requests and the board turn. The slave side is the     |
// |               sequencer.                                             |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface turn_sequencer_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
);
  // Player requester
  logic             p_req;
  logic [IDX_W-1:0] p_loc;
  logic             p_gnt;
  // AI requester
  logic             ai_req;
  logic [IDX_W-1:0] ai_loc;
  logic             ai_gnt;
  // Game control and board side
  logic             game_rst;
  logic             board_turn;
  logic [IDX_W-1:0] update_loc;
  logic             submit;
  logic             board_reset;
  // Status
  logic             busy;
  logic             done;
  logic             reject;
  logic [CNT_W-1:0] move_count;

  modport master (
    output p_req, p_loc, ai_req, ai_loc, game_rst, board_turn,
    input  p_gnt, ai_gnt, update_loc, submit, board_reset,
           busy, done, reject, move_count
  );

  modport slave (
    input  p_req, p_loc, ai_req, ai_loc, game_rst, board_turn,
    output p_gnt, ai_gnt, update_loc, submit, board_reset,
           busy, done, reject, move_count
  );
endinterface
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : turn_sequencer                                         |
// | Description : Serialises every write into the board state holder.    |
// |               It grants the requester whose turn the board reports   |
// |               and turns each grant into an update_loc/submit pulse.  |
// |               It runs the game-reset sequence. A move is accepted    |
// |               when the board turn flips; it is rejected when the     |
// |               flip does not arrive in time.                          |
// | Option      : TURN_SEQ_OOT_REJECT_EN - out-of-turn requests are      |
// |               granted and rejected immediately, not left pending.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module turn_sequencer #(
  parameter int CELLS     = 9,
  parameter int IDX_W     = 4,
  parameter int PULSE_LEN = 2,
  parameter int TIMEOUT   = 6,
  parameter int CNT_W     = 4
) (
  input wire              clk,
  input wire              rst_n,
  turn_sequencer_if.slave bus
);

  // One timer serves both the submit pulse and the flip timeout.
  localparam int               TMR_MAX     = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
  localparam int               TMR_W       = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W:0]   CELLS_X     = (IDX_W + 1)'(CELLS);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CELLS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_PULSE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RSETUP = 3'd4,
    S_RPULSE = 3'd5,
    S_RHOLD  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rst_pend_q, rst_pend_d;
  logic             turn_q, turn_d;
  logic [IDX_W-1:0] update_loc_q, update_loc_d;
  logic             submit_q, submit_d;
  logic             board_reset_q, board_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic             p_gnt_q, p_gnt_d;
  logic             ai_gnt_q, ai_gnt_d;
  logic [CNT_W-1:0] move_count_q, move_count_d;

  // Select the requester whose side matches the board turn.
  logic             in_req;
  logic [IDX_W-1:0] in_loc;
  logic             in_loc_ok;
  logic             gnt_hold;

  assign in_req    = bus.board_turn ? bus.ai_req : bus.p_req;
  assign in_loc    = bus.board_turn ? bus.ai_loc : bus.p_loc;
  assign in_loc_ok = ({1'b0, in_loc} < CELLS_X);
  // A request is still high in its grant cycle. Hold off, or it is served twice.
  assign gnt_hold  = p_gnt_q | ai_gnt_q;

`ifdef TURN_SEQ_OOT_REJECT_EN
  logic oot_req;
  assign oot_req = bus.board_turn ? bus.p_req : bus.ai_req;
`else
  // Out-of-turn requests need no decode; they wait for their turn.
`endif

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    rst_pend_d   = rst_pend_q | bus.game_rst;
    turn_d       = turn_q;
    update_loc_d = update_loc_q;
    move_count_d = move_count_q;
    p_gnt_d      = 1'b0;
    ai_gnt_d     = 1'b0;
    done_d       = 1'b0;
    reject_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rst_pend_q || bus.game_rst) begin
          state_d    = S_RSETUP;
          rst_pend_d = 1'b0;
        end else if (!gnt_hold) begin
          if (in_req) begin
            p_gnt_d  = ~bus.board_turn;
            ai_gnt_d = bus.board_turn;
            if (in_loc_ok) begin
              update_loc_d = in_loc;
              turn_d       = bus.board_turn;
              state_d      = S_SETUP;
            end else begin
              // An index off the board never reaches the board.
              reject_d = 1'b1;
            end
          end
`ifdef TURN_SEQ_OOT_REJECT_EN
          else if (oot_req) begin
            p_gnt_d  = bus.board_turn;
            ai_gnt_d = ~bus.board_turn;
            reject_d = 1'b1;
          end
`else
          // Out-of-turn requests stay pending until the turn comes round.
`endif
        end
      end

      S_SETUP: begin
        state_d = S_PULSE;
        tmr_d   = '0;
      end

      S_PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_WAIT: begin
        if (bus.board_turn != turn_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (move_count_q < CNT_SAT) begin
            move_count_d = move_count_q + CNT_W'(1);
          end
        end else if (tmr_q == TIMEOUT_LAST) begin
          // The board did not flip, so it refused the move (cell occupied).
          reject_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RSETUP: begin
        state_d = S_RPULSE;
        tmr_d   = '0;
      end

      S_RPULSE: begin
        if (tmr_q == PULSE_LAST) begin
          state_d = S_RHOLD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RHOLD: begin
        // board_reset stays high one cycle past the submit fall, where the board samples it.
        state_d      = S_IDLE;
        move_count_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobe outputs follow the next state, so each one is a clean flop output.
    submit_d      = (state_d == S_PULSE) || (state_d == S_RPULSE);
    board_reset_d = (state_d == S_RSETUP) || (state_d == S_RPULSE) || (state_d == S_RHOLD);
    busy_d        = (state_d != S_IDLE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      rst_pend_q    <= 1'b0;
      turn_q        <= 1'b0;
      update_loc_q  <= '0;
      submit_q      <= 1'b0;
      board_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      reject_q      <= 1'b0;
      p_gnt_q       <= 1'b0;
      ai_gnt_q      <= 1'b0;
      move_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      rst_pend_q    <= rst_pend_d;
      turn_q        <= turn_d;
      update_loc_q  <= update_loc_d;
      submit_q      <= submit_d;
      board_reset_q <= board_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      reject_q      <= reject_d;
      p_gnt_q       <= p_gnt_d;
      ai_gnt_q      <= ai_gnt_d;
      move_count_q  <= move_count_d;
    end
  end

  assign bus.p_gnt       = p_gnt_q;
  assign bus.ai_gnt      = ai_gnt_q;
  assign bus.update_loc  = update_loc_q;
  assign bus.submit      = submit_q;
  assign bus.board_reset = board_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.reject      = reject_q;
  assign bus.move_count  = move_count_q;

endmodule
`default_nettype wire

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Sequences all writes into the board state holder.
- Arbitrates move requests between the player input path and the AI move generator, allowing only the side whose turn the board reports.
- Converts each granted request into a correctly timed update_loc/submit pulse, and the game-reset request into a reset/submit sequence.
- Detects acceptance (board turn flips) or silent rejection (occupied cell, no flip) and reports status to both requesters.

Parameters:
- CELLS, 9, number of board cells; a location >= CELLS is invalid.
- IDX_W, 4, width of cell index buses.
- PULSE_LEN, 2, cycles submit is held high (>= 1).
- TIMEOUT, 6, cycles waited after the submit falling edge for a turn flip before declaring reject (>= 2).
- CNT_W, 4, width of move_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  1  player move request, level, held until p_gnt.
- p_loc  in  IDX_W  player cell index, valid while p_req.
- p_gnt  out  1  one-cycle grant to player.
- ai_req  in  1  AI move request, level, held until ai_gnt.
- ai_loc  in  IDX_W  AI cell index, valid while ai_req.
- ai_gnt  out  1  one-cycle grant to AI.
- game_rst  in  1  game reset request, one-cycle pulse.
- board_turn  in  1  current turn from board: 0 = player, 1 = AI.
- update_loc  out  IDX_W  cell index to board.
- submit  out  1  board strobe; board acts on its falling edge.
- board_reset  out  1  board reset qualifier.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, move accepted.
- reject  out  1  one-cycle pulse, move rejected.
- move_count  out  CNT_W  accepted moves since last game reset, saturates at CELLS.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; rst_pend cleared; latched turn 0.
- States: IDLE, SETUP, PULSE, WAIT, RSETUP, RPULSE, RHOLD.
- rst_pend: set on game_rst in any state; cleared on entry to RSETUP.
- IDLE, evaluated in priority order:
  - rst_pend (or game_rst this cycle) -> RSETUP.
  - Requester matching board_turn asserting req:
    - Loc < CELLS: latch loc into update_loc; latch board_turn; pulse its gnt next cycle; -> SETUP.
    - Loc >= CELLS: pulse gnt and reject together next cycle; stay IDLE; no submit.
  - Requester whose side != board_turn: ignored; its req stays pending.
- SETUP: submit 0 for 1 cycle so update_loc is stable; -> PULSE.
- PULSE: submit 1 for exactly PULSE_LEN cycles; -> WAIT.
- WAIT: submit 0; counter runs from 0.
  - board_turn != latched turn: done pulse; move_count+1 (held at CELLS); -> IDLE.
  - Counter reaches TIMEOUT-1 with no flip: reject pulse; -> IDLE.
- Latency: req seen in IDLE -> gnt at +1; submit rises at +2 (after SETUP); submit falls at +2+PULSE_LEN. Minimum accepted turnaround is 4+PULSE_LEN cycles.
- Reset sequence:
  - RSETUP: board_reset 1, submit 0, 1 cycle.
  - RPULSE: board_reset 1, submit 1, PULSE_LEN cycles.
  - RHOLD: board_reset 1, submit 0, 1 cycle (board samples reset on the falling edge).
  - Then board_reset 0; move_count 0; -> IDLE.
  - No gnt, done or reject during the reset sequence.
- game_rst mid-move (SETUP/PULSE/WAIT): the current move completes normally, including done/reject; the reset sequence follows immediately from IDLE.
- Both p_req and ai_req high: only the side matching board_turn can be granted, so there is never a double grant.
- update_loc holds its last value outside SETUP/PULSE.
- board_turn changing during SETUP/PULSE: ignored; only the WAIT comparison matters.

Optional Feature:
- Macro: TURN_SEQ_OOT_REJECT_EN.
- Defined: in IDLE, an out-of-turn req (no in-turn req present, no reset pending) is granted with gnt+reject pulsed together next cycle; no submit.
- Not defined: out-of-turn requests are ignored and remain pending, as above.

Test Plan:
- Player move: board_turn=0, p_req with p_loc=4; model flips turn 1 cycle after submit falls -> p_gnt at +1, submit high cycles +2..+3 (PULSE_LEN=2), update_loc=4, done pulse, move_count 0->1.
- Occupied cell: board_turn=1, ai_req ai_loc=4; model never flips -> ai_gnt, submit pulse, reject exactly TIMEOUT cycles after submit falls, move_count unchanged.
- Invalid index: p_loc=9 with turn 0 -> p_gnt and reject same cycle, submit never asserted, state stays IDLE.
- Contention: p_req and ai_req both high with board_turn=1 -> only ai_gnt; p_req granted after the flip to 0; with TURN_SEQ_OOT_REJECT_EN, a lone p_req at turn 1 gets p_gnt+reject.
- game_rst during PULSE of a move -> move finishes with done; then board_reset high across submit 1-pulse and 1 cycle after its fall; move_count=0.
- Async reset: drop rst_n mid-WAIT -> all outputs 0 immediately; IDLE after release; 9 accepted moves followed by a 10th valid one -> move_count saturates at 9.
